uart_mem_loader: RTL and testbench

Serial program loader that receives a framed byte stream from the UART receive handshake and writes 32-bit words into the instruction/data block-RAM write port. It holds the MIPS150 core in stall while a frame is in progress. It answers each frame with a one-byte ACK or NAK on the UART transmit handshake. It sits between the UART instance and port A of imem/dmem, muxed against the core's store path by the top level using `cpu_hold`.

---
 rtl/uart_mem_loader.sv | 177 +++++++++++++++++
 tb/tb_uart_mem_loader.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_mem_loader.sv
`timescale 1ns/1ps
// Serial program loader: parses 'L' frames from the UART receive side, writes
// 32-bit words into a block-RAM port, stalls the core meanwhile, replies ACK/NAK.
module uart_mem_loader #(
    parameter int ADDR_W  = 12,
    parameter int TIMEOUT = 1_000_000,
    parameter int TO_W    = 20
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic [3:0]        mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_din,
    output logic              cpu_hold,
    output logic              load_done,
    output logic [2:0]        dbg_state
);
    localparam logic [7:0] CMD_L = 8'h4C;
    localparam logic [7:0] ACK   = 8'h06;
    localparam logic [7:0] NAK   = 8'h15;

    typedef enum logic [2:0] {
        S_IDLE, S_ADDR_H, S_ADDR_L, S_CNT_H, S_CNT_L, S_DATA, S_CSUM, S_RESP
    } state_t;

    state_t            state_q, state_d;
    logic [15:0]       addr_q, addr_d;
    logic [15:0]       cnt_q, cnt_d;
    logic [1:0]        idx_q, idx_d;
    logic [23:0]       word_q, word_d;
    logic [7:0]        sum_q, sum_d;
    logic [TO_W-1:0]   to_q, to_d;
    logic              tx_valid_q, tx_valid_d;
    logic [7:0]        tx_data_q, tx_data_d;
    logic [3:0]        we_q, we_d;
    logic [ADDR_W-1:0] maddr_q, maddr_d;
    logic [31:0]       din_q, din_d;
    logic              hold_q, hold_d;
    logic              done_q, done_d;
    logic              take;

    // Valid/ready: a byte moves on a rising edge where valid && ready are both
    // high; the sender holds data stable and valid high until that edge.
    assign rx_ready  = !rst && (state_q != S_RESP);
    assign take      = rx_valid && rx_ready;
    assign tx_data   = tx_data_q;
    assign tx_valid  = tx_valid_q;
    assign mem_we    = we_q;
    assign mem_addr  = maddr_q;
    assign mem_din   = din_q;
    assign cpu_hold  = hold_q;
    assign load_done = done_q;
    assign dbg_state = state_q;

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        word_d     = word_q;
        sum_d      = sum_q;
        to_d       = to_q;
        tx_valid_d = tx_valid_q;
        tx_data_d  = tx_data_q;
        we_d       = 4'h0;
        maddr_d    = maddr_q;
        din_d      = din_q;
        hold_d     = hold_q;
        done_d     = 1'b0;

        // Checksum covers header and data bytes, not 'L' nor CSUM itself.
        if (take && state_q >= S_ADDR_H && state_q <= S_DATA)
            sum_d = sum_q + rx_data;

        case (state_q)
            S_IDLE: begin
                to_d = '0;
                if (take && rx_data == CMD_L) begin
                    state_d = S_ADDR_H;
                    sum_d   = 8'h00;
                    hold_d  = 1'b1;
                end
            end
            S_ADDR_H, S_ADDR_L: if (take) begin
                addr_d  = {addr_q[7:0], rx_data};
                state_d = (state_q == S_ADDR_H) ? S_ADDR_L : S_CNT_H;
            end
            S_CNT_H: if (take) begin
                cnt_d   = {cnt_q[7:0], rx_data};
                state_d = S_CNT_L;
            end
            S_CNT_L: if (take) begin
                cnt_d   = {cnt_q[7:0], rx_data};
                idx_d   = 2'd0;
                state_d = ({cnt_q[7:0], rx_data} == 16'h0000) ? S_CSUM : S_DATA;
            end
            S_DATA: if (take) begin
                word_d = {word_q[15:0], rx_data};
                idx_d  = idx_q + 2'd1;
                if (idx_q == 2'd3) begin
                    we_d    = 4'hF;
                    maddr_d = addr_q[ADDR_W-1:0];
                    din_d   = {word_q, rx_data};
                    addr_d  = addr_q + 16'd1;
                    cnt_d   = cnt_q - 16'd1;
                    if (cnt_q == 16'd1)
                        state_d = S_CSUM;
                end
            end
            S_CSUM: if (take) begin
                state_d    = S_RESP;
                tx_valid_d = 1'b1;
                tx_data_d  = (rx_data == sum_q) ? ACK : NAK;
            end
            S_RESP: if (tx_ready) begin
                state_d    = S_IDLE;
                tx_valid_d = 1'b0;
                hold_d     = 1'b0;
                done_d     = (tx_data_q == ACK);
            end
            default: state_d = S_IDLE;
        endcase

        // Inter-byte watchdog; an accepted byte always wins over expiry.
        if (state_q != S_IDLE && state_q != S_RESP) begin
            if (take) begin
                to_d = '0;
            end else if (to_q == TO_W'(TIMEOUT)) begin
                state_d    = S_RESP;
                tx_valid_d = 1'b1;
                tx_data_d  = NAK;
            end else begin
                to_d = to_q + TO_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            cnt_q      <= '0;
            idx_q      <= '0;
            word_q     <= '0;
            sum_q      <= '0;
            to_q       <= '0;
            tx_valid_q <= 1'b0;
            tx_data_q  <= '0;
            we_q       <= '0;
            maddr_q    <= '0;
            din_q      <= '0;
            hold_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            word_q     <= word_d;
            sum_q      <= sum_d;
            to_q       <= to_d;
            tx_valid_q <= tx_valid_d;
            tx_data_q  <= tx_data_d;
            we_q       <= we_d;
            maddr_q    <= maddr_d;
            din_q      <= din_d;
            hold_q     <= hold_d;
            done_q     <= done_d;
        end
    end
endmodule

// File: tb/tb_uart_mem_loader.sv
`timescale 1ns/1ps
// Self-checking bench for uart_mem_loader: frames are built from the protocol
// rules, expected writes and responses come from that frame-level model.
module tb_uart_mem_loader;
    localparam logic [7:0] ACK = 8'h06;
    localparam logic [7:0] NAK = 8'h15;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [3:0]  mem_we;
    logic [11:0] mem_addr;
    logic [31:0] mem_din;
    logic        cpu_hold;
    logic        load_done;
    logic [2:0]  dbg_state;

    uart_mem_loader #(.ADDR_W(12), .TIMEOUT(100), .TO_W(20)) dut (
        .clk(clk), .rst(rst),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din),
        .cpu_hold(cpu_hold), .load_done(load_done), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    int          acc_cyc  = 0;
    int          done_cnt, hold_err, we_err;
    logic [43:0] exp_q[$];
    logic [43:0] got_wr[$];
    logic [7:0]  got_tx[$];
    logic [7:0]  frame_q[$];
    logic [31:0] wdata[$];
    logic [7:0]  exp_resp;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: runs just after the falling edge, when inputs for the next
    // rising edge are already driven and registered outputs are stable.
    always begin
        @(negedge clk);
        #1;
        if (!rst) begin
            if (mem_we == 4'hF) begin
                got_wr.push_back({mem_addr, mem_din});
                if (!cpu_hold) hold_err++;
            end else if (mem_we != 4'h0) begin
                we_err++;
            end
            if (tx_valid && tx_ready) begin
                got_tx.push_back(tx_data);
                if (!cpu_hold) hold_err++;
            end
            if (load_done) done_cnt++;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, got running want finished");
        $fatal(1, "watchdog");
    end

    // Reference model: frame bytes, expected writes (addr mod 4096) and reply.
    task automatic build_frame(input logic [15:0] a, input logic [7:0] corrupt);
        logic [7:0]  sum;
        logic [15:0] nn;
        logic [15:0] aw;
        logic [7:0]  hdr[4];
        frame_q.delete();
        exp_q.delete();
        nn  = 16'(wdata.size());
        hdr = '{a[15:8], a[7:0], nn[15:8], nn[7:0]};
        sum = 8'h00;
        frame_q.push_back(8'h4C);
        for (int i = 0; i < 4; i++) begin
            frame_q.push_back(hdr[i]);
            sum = sum + hdr[i];
        end
        for (int w = 0; w < wdata.size(); w++) begin
            for (int b = 3; b >= 0; b--) begin
                frame_q.push_back(wdata[w][b*8 +: 8]);
                sum = sum + wdata[w][b*8 +: 8];
            end
            aw = a + 16'(w);
            exp_q.push_back({aw[11:0], wdata[w]});
        end
        frame_q.push_back(sum + corrupt);
        exp_resp = (corrupt == 8'h00) ? ACK : NAK;
    endtask

    // Driver: called at a falling edge; returns at the falling edge after acceptance.
    task automatic send_byte(input logic [7:0] b, input int gap);
        int bound;
        rx_valid = 1'b0;
        repeat (gap) @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        bound    = 0;
        while (!rx_ready && bound < 200) begin
            @(negedge clk);
            bound++;
        end
        if (!rx_ready) begin
            n_checks++; n_fail++;
            $display("FAIL rx_accept: rx_ready got 0 want 1 within 200 cycles");
        end
        @(negedge clk);
        acc_cyc  = cyc;
        rx_valid = 1'b0;
    endtask

    task automatic run_frame(input string name, input int gap_max, input int stall);
        int bound;
        int stable_err;
        got_wr.delete(); got_tx.delete();
        done_cnt = 0; hold_err = 0; we_err = 0;
        tx_ready = (stall == 0);
        for (int i = 0; i < frame_q.size(); i++) begin
            send_byte(frame_q[i], $urandom_range(0, gap_max));
            if (i == 0) begin
                n_checks++;
                if (cpu_hold !== 1'b1) begin
                    n_fail++;
                    $display("FAIL %s hold_rise: cpu_hold got %b want 1", name, cpu_hold);
                end
            end
        end
        bound = 0;
        while (!tx_valid && bound < 50) begin @(negedge clk); bound++; end
        n_checks++;
        if (tx_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL %s tx_valid_rise: got %b want 1", name, tx_valid);
        end
        if (stall > 0) begin
            stable_err = 0;
            repeat (stall) begin
                if (tx_valid !== 1'b1 || tx_data !== exp_resp || cpu_hold !== 1'b1) stable_err++;
                @(negedge clk);
            end
            n_checks++;
            if (stable_err != 0) begin
                n_fail++;
                $display("FAIL %s backpressure: unstable cycles got %0d want 0", name, stable_err);
            end
            tx_ready = 1'b1;
        end
        bound = 0;
        while (got_tx.size() == 0 && bound < 50) begin @(negedge clk); bound++; end
        repeat (3) @(negedge clk);
        n_checks++;
        if (got_tx.size() != 1 || got_tx[0] !== exp_resp) begin
            n_fail++;
            $display("FAIL %s response: got %0d bytes first %h want 1 byte %h", name,
                     got_tx.size(), (got_tx.size() > 0) ? got_tx[0] : 8'hxx, exp_resp);
        end
        n_checks++;
        if (got_wr.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL %s write_count: got %0d want %0d", name, got_wr.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            n_checks++;
            if (i >= got_wr.size() || got_wr[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL %s write[%0d]: got addr/data %h want %h", name, i,
                         (i < got_wr.size()) ? got_wr[i] : 44'hx, exp_q[i]);
            end
        end
        n_checks++;
        if (done_cnt != ((exp_resp == ACK) ? 1 : 0)) begin
            n_fail++;
            $display("FAIL %s load_done: pulses got %0d want %0d", name, done_cnt,
                     (exp_resp == ACK) ? 1 : 0);
        end
        n_checks++;
        if (hold_err != 0 || we_err != 0 || cpu_hold !== 1'b0 || dbg_state !== 3'd0) begin
            n_fail++;
            $display("FAIL %s hold_span: hold_err %0d we_err %0d cpu_hold %b state %0d want 0 0 0 0",
                     name, hold_err, we_err, cpu_hold, dbg_state);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; tx_ready = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if (rx_ready !== 1'b0) begin
            n_fail++; $display("FAIL reset_rx_ready: got %b want 0", rx_ready);
        end
        n_checks++;
        if ({tx_valid, tx_data, mem_we, mem_addr, mem_din, cpu_hold, load_done} !== 59'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got tv %b td %h we %h a %h d %h h %b ld %b want all 0",
                     tx_valid, tx_data, mem_we, mem_addr, mem_din, cpu_hold, load_done);
        end
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (rx_ready !== 1'b1 || dbg_state !== 3'd0) begin
            n_fail++; $display("FAIL reset_idle: rx_ready %b state %0d want 1 0", rx_ready, dbg_state);
        end
    endtask

    task automatic test_basic();
        wdata = '{32'h11223344, 32'hA0B0C0D0};
        build_frame(16'h0010, 8'h00);
        run_frame("basic", 0, 0);
        build_frame(16'h0010, 8'h01);
        run_frame("bad_csum", 0, 0);
    endtask

    task automatic test_zero_and_wrap();
        wdata.delete();
        build_frame(16'h0123, 8'h00);
        run_frame("zero_count", 1, 0);
        wdata = '{$urandom, $urandom};
        build_frame(16'h0FFF, 8'h00);
        run_frame("wrap", 1, 0);
    endtask

    task automatic test_random();
        for (int f = 0; f < 6; f++) begin
            wdata.delete();
            repeat ($urandom_range(0, 4)) wdata.push_back($urandom);
            build_frame(16'($urandom_range(0, 65535)),
                        ($urandom_range(0, 2) == 0) ? 8'($urandom_range(1, 255)) : 8'h00);
            run_frame($sformatf("random%0d", f), (f % 2 == 0) ? 0 : 3, 0);
        end
    endtask

    task automatic test_timeout();
        int t0, bound;
        got_tx.delete(); done_cnt = 0; tx_ready = 1'b1;
        send_byte(8'h4C, 0);
        send_byte(8'h00, 0);
        send_byte(8'h10, 0);
        t0 = acc_cyc;
        bound = 0;
        while (!tx_valid && bound < 300) begin @(negedge clk); bound++; end
        n_checks++;
        if (cyc - t0 != 101 || tx_valid !== 1'b1) begin
            n_fail++; $display("FAIL timeout_latency: got %0d cycles want 101", cyc - t0);
        end
        n_checks++;
        if (tx_data !== NAK) begin
            n_fail++; $display("FAIL timeout_nak: tx_data got %h want %h", tx_data, NAK);
        end
        repeat (3) @(negedge clk);
        n_checks++;
        if (cpu_hold !== 1'b0 || dbg_state !== 3'd0 || done_cnt != 0 || got_tx.size() != 1) begin
            n_fail++;
            $display("FAIL timeout_recover: hold %b state %0d done %0d tx %0d want 0 0 0 1",
                     cpu_hold, dbg_state, done_cnt, got_tx.size());
        end
        wdata = '{$urandom};
        build_frame(16'h0040, 8'h00);
        run_frame("after_timeout", 0, 0);
    endtask

    task automatic test_noise_backpressure();
        got_tx.delete(); tx_ready = 1'b1;
        send_byte(8'h00, 0);
        send_byte(8'hFF, 0);
        repeat (5) @(negedge clk);
        n_checks++;
        if (got_tx.size() != 0 || cpu_hold !== 1'b0 || dbg_state !== 3'd0) begin
            n_fail++;
            $display("FAIL noise: tx %0d hold %b state %0d want 0 0 0", got_tx.size(), cpu_hold, dbg_state);
        end
        wdata = '{$urandom, $urandom};
        build_frame(16'($urandom_range(0, 65535)), 8'h00);
        run_frame("backpressure", 1, 50);
    endtask

    task automatic test_reset_midframe();
        wdata = '{$urandom, $urandom, $urandom};
        build_frame(16'h0200, 8'h00);
        got_tx.delete(); tx_ready = 1'b1;
        for (int i = 0; i < 11; i++) send_byte(frame_q[i], 0);
        rst = 1'b1;
        #1;
        n_checks++;
        if (rx_ready !== 1'b0) begin
            n_fail++; $display("FAIL midreset_rx_ready: got %b want 0", rx_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        n_checks++;
        if ({tx_valid, tx_data, mem_we, mem_addr, mem_din, cpu_hold, load_done} !== 59'd0
            || dbg_state !== 3'd0) begin
            n_fail++;
            $display("FAIL midreset_outputs: tv %b td %h we %h a %h d %h h %b ld %b st %0d want all 0",
                     tx_valid, tx_data, mem_we, mem_addr, mem_din, cpu_hold, load_done, dbg_state);
        end
        repeat (20) @(negedge clk);
        n_checks++;
        if (got_tx.size() != 0) begin
            n_fail++; $display("FAIL midreset_no_resp: got %0d responses want 0", got_tx.size());
        end
        wdata = '{$urandom, $urandom};
        build_frame(16'h0300, 8'h00);
        run_frame("after_reset", 0, 0);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero_and_wrap();
        test_random();
        test_timeout();
        test_noise_backpressure();
        test_reset_midframe();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
